ccd_pattern_source: RTL and testbench



---
 rtl/ccd_pkg.sv | 41 ++++
 rtl/ccd_pattern_pixel.sv | 42 ++++
 rtl/ccd_pattern_source.sv | 196 +++++++++++++++++++
 tb/tb_ccd_pattern_source.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ccd_pkg.sv
// Shared types and tables for the synthetic CCD pattern source.
// States, pattern modes, colour-bar table and Bayer site encoding.
package ccd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VBLANK,
        ST_FSETUP,
        ST_ACTIVE,
        ST_HBLANK,
        ST_FHOLD
    } state_e;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_RAMP  = 2'd1,
        MODE_FRAME = 2'd2,
        MODE_CONST = 2'd3
    } mode_e;

    // Encoded as {y[0], x[0]}
    typedef enum logic [1:0] {
        SITE_G0 = 2'd0,
        SITE_R  = 2'd1,
        SITE_B  = 2'd2,
        SITE_G1 = 2'd3
    } site_e;

    // {R,G,B}: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [0:7][2:0] BAR_RGB = {
        3'b111, 3'b110, 3'b011, 3'b010,
        3'b101, 3'b100, 3'b001, 3'b000
    };

    localparam logic [11:0] PIX_ON = 12'hFFF;

    function automatic site_e bayer_site(input logic x0, input logic y0);
        return site_e'({y0, x0});
    endfunction

endpackage

// File: rtl/ccd_pattern_pixel.sv
// Combinational test-pattern pixel generator.
// Maps (mode, x, y, frame, const) to a 12-bit Bayer sample.
module ccd_pattern_pixel
    import ccd_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640
) (
    input  logic [1:0]  imode,
    input  logic [15:0] ix,
    input  logic        iy0,
    input  logic [11:0] iframe,
    input  logic [11:0] iconst,
    output logic [11:0] opix
);

    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic [2:0] bar;
    logic [2:0] rgb;
    logic       lit;

    always_comb begin
        bar = 3'(ix / 16'(BAR_W));
        rgb = BAR_RGB[bar];
        lit = 1'b0;
        unique case (bayer_site(ix[0], iy0))
            SITE_R:  lit = rgb[2];
            SITE_B:  lit = rgb[0];
            SITE_G0: lit = rgb[1];
            SITE_G1: lit = rgb[1];
        endcase

        opix = '0;
        unique case (mode_e'(imode))
            MODE_BARS:  opix = lit ? PIX_ON : 12'h000;
            MODE_RAMP:  opix = ix[11:0];
            MODE_FRAME: opix = iframe;
            MODE_CONST: opix = iconst;
        endcase
    end

endmodule

// File: rtl/ccd_pattern_source.sv
// Synthetic D5M-style sensor transmitter: timed FVAL/LVAL frames
// carrying selectable Bayer test patterns. Outputs lag state by one cycle.
module ccd_pattern_source
    import ccd_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned H_BLANK  = 32,
    parameter int unsigned V_BLANK  = 64,
    parameter int unsigned FV_SETUP = 2,
    parameter int unsigned FV_HOLD  = 2
) (
    input  logic        iclk,
    input  logic        irst_n,
    input  logic        istart,
    input  logic        istop,
    input  logic [1:0]  imode,
    input  logic [11:0] iconst,
    output logic [11:0] odata,
    output logic        ofval,
    output logic        olval,
    output logic [15:0] ox_cont,
    output logic [15:0] oy_cont,
    output logic [31:0] oframe_cont,
    output logic        obusy
);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [31:0] frame_q, frame_d;
    logic [1:0]  mode_q, mode_d;
    logic [11:0] const_q, const_d;
    logic        stop_q, stop_d;

    logic [11:0] odata_q, odata_d;
    logic        ofval_q, ofval_d;
    logic        olval_q, olval_d;
    logic [15:0] ox_cont_q, ox_cont_d;
    logic [15:0] oy_cont_q, oy_cont_d;
    logic [31:0] oframe_cont_q, oframe_cont_d;
    logic        obusy_q, obusy_d;

    logic        cnt_last;
    logic        stop_seen;
    logic [11:0] pix;

    ccd_pattern_pixel #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pixel (
        .imode  (mode_q),
        .ix     (x_q),
        .iy0    (y_q[0]),
        .iframe (frame_q[11:0]),
        .iconst (const_q),
        .opix   (pix)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        frame_d   = frame_q;
        mode_d    = mode_q;
        const_d   = const_q;
        stop_seen = stop_q | istop;
        stop_d    = stop_seen;
        cnt_last  = (cnt_q == 16'd0);
        if (!cnt_last) begin
            cnt_d = cnt_q - 16'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                stop_d = 1'b0;
                if (istart && !istop) begin
                    state_d = ST_VBLANK;
                    cnt_d   = 16'(V_BLANK - 1);
                end
            end
            ST_VBLANK: begin
                if (cnt_last) begin
                    if (stop_seen) begin
                        state_d = ST_IDLE;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = ST_FSETUP;
                        cnt_d   = 16'(FV_SETUP - 1);
                        mode_d  = imode;
                        const_d = iconst;
                        x_d     = '0;
                        y_d     = '0;
                    end
                end
            end
            ST_FSETUP: begin
                if (cnt_last) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = 16'(H_ACTIVE - 1);
                end
            end
            ST_ACTIVE: begin
                if (!cnt_last) begin
                    x_d = x_q + 16'd1;
                end else if (y_q == 16'(V_ACTIVE - 1)) begin
                    state_d = ST_FHOLD;
                    cnt_d   = 16'(FV_HOLD - 1);
                end else begin
                    state_d = ST_HBLANK;
                    cnt_d   = 16'(H_BLANK - 1);
                    x_d     = '0;
                    y_d     = y_q + 16'd1;
                end
            end
            ST_HBLANK: begin
                if (cnt_last) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = 16'(H_ACTIVE - 1);
                end
            end
            ST_FHOLD: begin
                if (cnt_last) begin
                    frame_d = frame_q + 32'd1;
                    if (stop_seen) begin
                        state_d = ST_IDLE;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = ST_VBLANK;
                        cnt_d   = 16'(V_BLANK - 1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                stop_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        ofval_d       = state_q inside {ST_FSETUP, ST_ACTIVE, ST_HBLANK, ST_FHOLD};
        olval_d       = (state_q == ST_ACTIVE);
        odata_d       = olval_d ? pix : 12'h000;
        ox_cont_d     = x_q;
        oy_cont_d     = y_q;
        oframe_cont_d = frame_q;
        obusy_d       = (state_q != ST_IDLE);
    end

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            frame_q       <= '0;
            mode_q        <= '0;
            const_q       <= '0;
            stop_q        <= 1'b0;
            odata_q       <= '0;
            ofval_q       <= 1'b0;
            olval_q       <= 1'b0;
            ox_cont_q     <= '0;
            oy_cont_q     <= '0;
            oframe_cont_q <= '0;
            obusy_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_q       <= frame_d;
            mode_q        <= mode_d;
            const_q       <= const_d;
            stop_q        <= stop_d;
            odata_q       <= odata_d;
            ofval_q       <= ofval_d;
            olval_q       <= olval_d;
            ox_cont_q     <= ox_cont_d;
            oy_cont_q     <= oy_cont_d;
            oframe_cont_q <= oframe_cont_d;
            obusy_q       <= obusy_d;
        end
    end

    assign odata       = odata_q;
    assign ofval       = ofval_q;
    assign olval       = olval_q;
    assign ox_cont     = ox_cont_q;
    assign oy_cont     = oy_cont_q;
    assign oframe_cont = oframe_cont_q;
    assign obusy       = obusy_q;

endmodule

// File: tb/tb_ccd_pattern_source.sv
// Directed bench for ccd_pattern_source: an 8-pixel-line instance and
// a 16-pixel-line instance sharing clock, reset and pattern inputs.
module tb_ccd_pattern_source;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, stop_a, start_b, stop_b;
    logic [1:0]  mode;
    logic [11:0] cval;

    logic [11:0] data_a, data_b;
    logic        fval_a, fval_b, lval_a, lval_b, busy_a, busy_b;
    logic [15:0] x_a, x_b, y_a, y_b;
    logic [31:0] frame_a, frame_b;

    int total = 0;
    int bad   = 0;

    // Hand-derived colour-bar rows (even line: G/R sites, odd line: B/G)
    logic [11:0] bars_even [8] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'h000,
                                   12'h000, 12'hFFF, 12'h000, 12'h000};
    logic [11:0] bars_odd  [8] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF,
                                   12'hFFF, 12'h000, 12'hFFF, 12'h000};

    always #5 clk = ~clk;

    ccd_pattern_source #(
        .H_ACTIVE (8), .V_ACTIVE (4), .H_BLANK (4),
        .V_BLANK  (6), .FV_SETUP (2), .FV_HOLD (2)
    ) u_a (
        .iclk (clk), .irst_n (rst_n), .istart (start_a), .istop (stop_a),
        .imode (mode), .iconst (cval), .odata (data_a), .ofval (fval_a),
        .olval (lval_a), .ox_cont (x_a), .oy_cont (y_a),
        .oframe_cont (frame_a), .obusy (busy_a)
    );

    ccd_pattern_source #(
        .H_ACTIVE (16), .V_ACTIVE (4), .H_BLANK (4),
        .V_BLANK  (6), .FV_SETUP (2), .FV_HOLD (2)
    ) u_b (
        .iclk (clk), .irst_n (rst_n), .istart (start_b), .istop (stop_b),
        .imode (mode), .iconst (cval), .odata (data_b), .ofval (fval_b),
        .olval (lval_b), .ox_cont (x_b), .oy_cont (y_b),
        .oframe_cont (frame_b), .obusy (busy_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] got,
                       input logic [79:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic wait_rise(input bit b, output int n);
        n = 0;
        while (!(b ? fval_b : fval_a) && n < 100) begin
            tick;
            n++;
        end
    endtask

    // Called at the sample where ofval has just risen; returns one
    // full frame period later.
    task automatic run_frame(input bit b, input int h, input int md,
                             input logic [11:0] cv, input logic [31:0] fc,
                             input int stop_t, input string tag);
        int per, fv_end, l, p;
        logic efv, elv, fv, lv;
        logic [11:0] ed, d;
        logic [15:0] x, y;
        logic [31:0] efr, fr;
        per    = 4 * h + 22;
        fv_end = 4 * h + 16;
        for (int t = 0; t < per; t++) begin
            l   = (t >= 2) ? (t - 2) / (h + 4) : 0;
            p   = (t >= 2) ? (t - 2) % (h + 4) : h;
            efv = (t < fv_end);
            elv = (t >= 2) && (l < 4) && (p < h);
            efr = (t < fv_end) ? fc : fc + 32'd1;
            ed  = 12'h000;
            if (elv) begin
                case (md)
                    0:       ed = l[0] ? bars_odd[p] : bars_even[p];
                    1:       ed = 12'(p);
                    2:       ed = fc[11:0];
                    default: ed = cv;
                endcase
            end
            fv = b ? fval_b : fval_a;
            lv = b ? lval_b : lval_a;
            d  = b ? data_b : data_a;
            x  = b ? x_b : x_a;
            y  = b ? y_b : y_a;
            fr = b ? frame_b : frame_a;
            chk($sformatf("%s t=%0d", tag, t),
                80'({fv, lv, d, lv ? x : 16'h0, lv ? y : 16'h0, fr}),
                80'({efv, elv, ed, elv ? 16'(p) : 16'h0,
                     elv ? 16'(l) : 16'h0, efr}));
            if (t == stop_t) begin
                if (b) stop_b = 1'b1; else stop_a = 1'b1;
            end
            if (t == stop_t + 1) begin
                stop_a = 1'b0;
                stop_b = 1'b0;
            end
            tick;
        end
    endtask

    initial begin
        int  n;
        bit  seen;
        rst_n   = 1'b0;
        start_a = 1'b0;
        stop_a  = 1'b0;
        start_b = 1'b0;
        stop_b  = 1'b0;
        mode    = 2'd0;
        cval    = 12'h000;
        tick;
        tick;
        chk("reset_a", 80'({fval_a, lval_a, data_a, x_a, y_a, frame_a, busy_a}),
            80'(0));
        rst_n = 1'b1;
        tick;

        // 16-pixel ramp, stop during line 2
        mode    = 2'd1;
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        wait_rise(1'b1, n);
        chk("b_rise", 80'(n), 80'(7));
        run_frame(1'b1, 16, 1, 12'h000, 32'd0, 2 + 2 * 20 + 3, "b_ramp");
        chk("b_idle", 80'({fval_b, busy_b, frame_b}), 80'({2'b00, 32'd1}));

        // Colour bars; mode change mid-frame must not leak in
        mode    = 2'd0;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        wait_rise(1'b0, n);
        chk("a_rise", 80'(n), 80'(7));
        mode = 2'd3;
        cval = 12'hABC;
        run_frame(1'b0, 8, 0, 12'h000, 32'd0, -1, "bars");
        chk("period", 80'(fval_a), 80'(1));
        mode = 2'd1;
        cval = 12'h123;
        run_frame(1'b0, 8, 3, 12'hABC, 32'd1, -1, "const");
        mode = 2'd2;
        run_frame(1'b0, 8, 1, 12'h000, 32'd2, -1, "ramp");
        mode = 2'd0;
        run_frame(1'b0, 8, 2, 12'h000, 32'd3, 28, "fill_stop");
        chk("stop_idle", 80'({fval_a, busy_a, frame_a}), 80'({2'b00, 32'd4}));
        repeat (10) tick;
        chk("stay_idle", 80'({fval_a, busy_a}), 80'(0));

        // start and stop together in IDLE
        start_a = 1'b1;
        stop_a  = 1'b1;
        repeat (10) tick;
        chk("both_idle", 80'(busy_a), 80'(0));
        start_a = 1'b0;
        stop_a  = 1'b0;

        // stop inside VBLANK: no frame emitted
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        tick;
        tick;
        chk("vb_busy", 80'(busy_a), 80'(1));
        stop_a = 1'b1;
        tick;
        stop_a = 1'b0;
        seen   = 1'b0;
        repeat (20) begin
            tick;
            if (fval_a) seen = 1'b1;
        end
        chk("vb_nofv", 80'(seen), 80'(0));
        chk("vb_idle", 80'({busy_a, frame_a}), 80'({1'b0, 32'd4}));

        // reset during active line 1
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        wait_rise(1'b0, n);
        chk("rst_rise", 80'(n), 80'(7));
        repeat (17) tick;
        chk("rst_pre", 80'({lval_a, y_a, x_a}), 80'({1'b1, 16'd1, 16'd3}));
        rst_n = 1'b0;
        tick;
        chk("rst_out", 80'({fval_a, lval_a, data_a, x_a, y_a, frame_a, busy_a}),
            80'(0));
        rst_n = 1'b1;
        repeat (60) tick;
        chk("rst_idle", 80'({busy_a, fval_a, frame_a}), 80'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
